// File: rtl/color_sense_pkg.sv
// Shared types for the colour sensor frame sequencer: S2/S3 filter codes,
// FSM state encoding and the channel index with its filter mapping.
package color_sense_pkg;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_STORE,
    ST_DONE
  } state_t;

  // Measurement order is the enum order: red, green, blue, then clear.
  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2,
    CH_CLEAR = 2'd3
  } ch_t;

  function automatic logic [1:0] ch_filter(input ch_t ch);
    logic [1:0] code;
    case (ch)
      CH_RED:   code = FILT_RED;
      CH_GREEN: code = FILT_GREEN;
      CH_BLUE:  code = FILT_BLUE;
      default:  code = FILT_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Brings the asynchronous sensor frequency output into the clk domain
// (two-flop synchroniser) and emits a one-cycle registered pulse per rising
// edge. Total latency from pin to pulse-consumed is three clk cycles.
module freq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic freq_in,
  output logic edge_vld
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;
  logic edge_vld_p3;

  // Synchroniser chain, previous-level history and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      prev_p2     <= 1'b0;
      edge_vld_p3 <= 1'b0;
    end else begin
      sync_p0     <= freq_in;
      sync_p1     <= sync_p0;
      prev_p2     <= sync_p1;
      edge_vld_p3 <= sync_p1 & ~prev_p2;
    end
  end

  assign edge_vld = edge_vld_p3;

endmodule

// File: rtl/color_sense_ctrl.sv
// Frame sequencer for a TCS3200-style colour sensor. Steps the filter
// through red/green/blue (and clear when COLOR_SENSE_CLEAR_MEAS_EN is
// defined), waits a settle time after each switch, counts sensor pulses over
// a gate window and publishes one coherent count set per frame with done.
module color_sense_ctrl
  import color_sense_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int GATE_CYCLES   = 100000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             freq_in,
  output logic [1:0]       filter_select,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] r_count,
  output logic [CNT_W-1:0] g_count,
  output logic [CNT_W-1:0] b_count,
  output logic [CNT_W-1:0] c_count,
  output logic             sat
);

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  // One extra code so the full cycle count itself can be loaded.
  localparam int TMR_W = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(1);
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
  localparam ch_t LAST_CH = CH_CLEAR;
`else
  localparam ch_t LAST_CH = CH_BLUE;
`endif

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, next_state;
  ch_t              ch;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] pulse_cnt;
  logic             sat_pending;
  logic [CNT_W-1:0] r_sh;
  logic [CNT_W-1:0] g_sh;
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
  logic [CNT_W-1:0] b_sh;
`endif
  logic             edge_vld;

  logic ld_settle, ld_gate, tmr_dec;
  logic cnt_clr, cnt_en, store_en, publish;
  logic ch_rst, ch_adv, sat_clr;

  freq_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .freq_in  (freq_in),
    .edge_vld (edge_vld)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode plus the per-state control strobes and status outputs.
  always_comb begin
    next_state = state;
    ld_settle  = 1'b0;
    ld_gate    = 1'b0;
    tmr_dec    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    store_en   = 1'b0;
    publish    = 1'b0;
    ch_rst     = 1'b0;
    ch_adv     = 1'b0;
    sat_clr    = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || continuous) begin
          next_state = ST_SETTLE;
          ld_settle  = 1'b1;
          ch_rst     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr == TMR_LAST) begin
          next_state = ST_GATE;
          ld_gate    = 1'b1;
          cnt_clr    = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GATE: begin
        cnt_en = 1'b1;
        if (tmr == TMR_LAST) next_state = ST_STORE;
        else                 tmr_dec    = 1'b1;
      end
      ST_STORE: begin
        store_en = 1'b1;
        if (ch == LAST_CH) begin
          next_state = ST_DONE;
          publish    = 1'b1;
        end else begin
          next_state = ST_SETTLE;
          ch_adv     = 1'b1;
          ld_settle  = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        sat_clr = 1'b1;
        if (continuous) begin
          next_state = ST_SETTLE;
          ld_settle  = 1'b1;
          ch_rst     = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Channel index; the filter code follows it so both switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ch <= CH_RED;
    else if (ch_rst) ch <= CH_RED;
    else if (ch_adv) ch <= ch_t'(ch + 2'd1);
  end

  assign filter_select = ch_filter(ch);

  // Shared settle/gate down-counter, terminal value 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tmr <= '0;
    else if (ld_settle) tmr <= SETTLE_LD;
    else if (ld_gate)   tmr <= GATE_LD;
    else if (tmr_dec)   tmr <= tmr - TMR_W'(1);
  end

  // Gate-window pulse counter with sticky saturation flag for the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt   <= '0;
      sat_pending <= 1'b0;
    end else begin
      if (cnt_clr)                 pulse_cnt <= '0;
      else if (cnt_en && edge_vld) pulse_cnt <= sat_inc(pulse_cnt);
      if (sat_clr)                                sat_pending <= 1'b0;
      else if (cnt_en && edge_vld && &pulse_cnt)  sat_pending <= 1'b1;
    end
  end

  // Per-channel shadows; the final channel skips its shadow and is taken
  // straight from the pulse counter when the frame is published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
      g_sh <= '0;
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
      b_sh <= '0;
`endif
    end else if (store_en) begin
      case (ch)
        CH_RED:   r_sh <= pulse_cnt;
        CH_GREEN: g_sh <= pulse_cnt;
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
        CH_BLUE:  b_sh <= pulse_cnt;
`endif
        default: ;
      endcase
    end
  end

  // Published frame: loaded on entry to DONE so it is valid while done=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      g_count <= '0;
      b_count <= '0;
      sat     <= 1'b0;
    end else if (publish) begin
      r_count <= r_sh;
      g_count <= g_sh;
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
      b_count <= b_sh;
`else
      b_count <= pulse_cnt;
`endif
      sat     <= sat_pending;
    end
  end

`ifdef COLOR_SENSE_CLEAR_MEAS_EN
  // Clear-channel result, published alongside the colour counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       c_count <= '0;
    else if (publish) c_count <= pulse_cnt;
  end
`else
  assign c_count = '0;
`endif

endmodule

// File: tb/tb_color_sense_ctrl.sv
// Scoreboard bench for color_sense_ctrl: two instances (8-bit and 3-bit
// counts) share all inputs; expected frames are computed from the freq_in
// waveform and frame timing, queued at start, and popped on each done.
module tb_color_sense_ctrl;

  localparam int S    = 4;
  localparam int G    = 16;
  localparam int CH   = S + G + 1;
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
  localparam int NCH  = 4;
`else
  localparam int NCH  = 3;
`endif
  localparam int FLEN = NCH * CH + 1;
  localparam int FMAX = 8192;

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, freq_in;
  logic [1:0] filt8, filt3;
  logic       busy8, done8, sat8, busy3, done3, sat3;
  logic [7:0] r8, g8, b8, c8;
  logic [2:0] r3, g3, b3, c3;

  typedef struct {
    int due;
    int r;
    int g;
    int b;
    int c;
    int sat;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  exp_t m8, m3;
  bit   f[FMAX];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  color_sense_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .freq_in(freq_in), .filter_select(filt8), .busy(busy8), .done(done8),
    .r_count(r8), .g_count(g8), .b_count(b8), .c_count(c8), .sat(sat8));

  color_sense_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .freq_in(freq_in), .filter_select(filt3), .busy(busy3), .done(done3),
    .r_count(r3), .g_count(g3), .b_count(b3), .c_count(c3), .sat(sat3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // f[n] is the freq_in level seen by posedge number n.
  always @(negedge clk) freq_in = (cyc + 1 < FMAX) ? f[cyc+1] : 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame whose start is sampled at edge s measures channel c
  // during gate cycles s+c*CH+S .. +G-1; a freq_in rise seen at edge k is
  // counted at edge k+3. Counts clip at 2^w-1, any clip flags sat.
  function automatic exp_t model(input int s, input int w);
    exp_t x;
    int   cnt[4];
    int   mx, n, e;
    mx    = (1 << w) - 1;
    cnt   = '{default: 0};
    x.sat = 0;
    for (int c = 0; c < NCH; c++) begin
      n = 0;
      for (int i = 0; i < G; i++) begin
        e = s + c * CH + S + i + 1;
        if (f[e-3] && !f[e-4]) n++;
      end
      if (n > mx) begin
        cnt[c] = mx;
        x.sat  = 1;
      end else begin
        cnt[c] = n;
      end
    end
    x.due = s + FLEN - 1;
    x.r   = cnt[0];
    x.g   = cnt[1];
    x.b   = cnt[2];
    x.c   = cnt[3];
    return x;
  endfunction

  task automatic fill_period(input int a, input int b, input int p);
    for (int i = a; i <= b; i++) f[i] = ((i % p) < (p / 2));
  endtask

  task automatic fill_rand(input int a, input int b);
    for (int i = a; i <= b; i++) f[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_zero(input int a, input int b);
    for (int i = a; i <= b; i++) f[i] = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_frame(input int s);
    q8.push_back(model(s, 8));
    q3.push_back(model(s, 3));
  endtask

  task automatic start_frame(output int s);
    s = cyc + 1;
    expect_frame(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_q8_left"}, q8.size(), 0);
    check({tag, "_q3_left"}, q3.size(), 0);
  endtask

  // Monitor, 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done=1 at cyc %0d, required no done", cyc);
      end else begin
        m8 = q8.pop_front();
        check("d8_time", cyc, m8.due);
        check("d8_r", r8, m8.r);
        check("d8_g", g8, m8.g);
        check("d8_b", b8, m8.b);
        check("d8_c", c8, m8.c);
        check("d8_sat", sat8, m8.sat);
      end
    end
  end

  // Monitor, 3-bit instance.
  always @(negedge clk) begin
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done3_unexpected: got done=1 at cyc %0d, required no done", cyc);
      end else begin
        m3 = q3.pop_front();
        check("d3_time", cyc, m3.due);
        check("d3_r", r3, m3.r);
        check("d3_g", g3, m3.g);
        check("d3_b", b3, m3.b);
        check("d3_c", c3, m3.c);
        check("d3_sat", sat3, m3.sat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_filt", filt8, 0);
    check("rst_sat", sat8, 0);
    check("rst_r", r8, 0);
    check("rst_c3", c3, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy8, 0);

    // 1: period-4 input on every channel, filter stepping and busy window.
    fill_period(cyc + 2, cyc + 2 * FLEN, 4);
    start_frame(s);
    wait_until(s + 1);
    check("t1_busy_rise", busy8, 1);
    check("t1_filt_red", filt8, 0);
    wait_until(s + CH - 1);
    check("t1_filt_red_store", filt8, 0);
    wait_until(s + CH);
    check("t1_filt_green", filt8, 3);
    wait_until(s + 2 * CH);
    check("t1_filt_blue", filt8, 1);
`ifdef COLOR_SENSE_CLEAR_MEAS_EN
    wait_until(s + 3 * CH);
    check("t1_filt_clear", filt8, 2);
`endif
    wait_until(s + FLEN - 1);
    check("t1_busy_done", busy8, 1);
    wait_until(s + FLEN);
    check("t1_busy_fall", busy8, 0);
    check_drained("t1");

    // 2: pulses only while red is measured.
    fill_zero(cyc + 2, cyc + 2 * FLEN);
    fill_period(cyc + 2, cyc + 1 + CH, 4);
    start_frame(s);
    wait_until(s + FLEN + 2);
    check_drained("t2");

    // 3: period-2 input saturates the 3-bit counts; next frame clears sat.
    fill_period(cyc + 2, cyc + 2 * FLEN, 2);
    start_frame(s);
    wait_until(s + FLEN + 2);
    check("t3_sat3_set", sat3, 1);
    check("t3_r3_clip", r3, 7);
    fill_period(cyc + 2, cyc + 2 * FLEN, 8);
    start_frame(s);
    wait_until(s + FLEN + 2);
    check("t3_sat3_clear", sat3, 0);
    check_drained("t3");

    // 4: start pulses while busy, including one during the done cycle.
    fill_rand(cyc + 2, cyc + 4 * FLEN);
    start_frame(s);
    wait_until(s + 5);
    pulse_start();
    wait_until(s + 30);
    pulse_start();
    wait_until(s + FLEN - 1);
    pulse_start();
    wait_until(s + 3 * FLEN);
    check("t4_idle", busy8, 0);
    check_drained("t4");

    // 5: continuous frames back to back, dropped during the third frame.
    fill_rand(cyc + 2, cyc + 5 * FLEN);
    s = cyc + 1;
    for (int k = 0; k < 3; k++) expect_frame(s + k * FLEN);
    continuous = 1'b1;
    wait_until(s + 2 * FLEN + 30);
    continuous = 1'b0;
    wait_until(s + 4 * FLEN);
    check("t5_idle", busy8, 0);
    check_drained("t5");

    // 6: reset during the green gate window, then a fresh frame.
    fill_rand(cyc + 2, cyc + 2 * FLEN);
    start_frame(s);
    wait_until(s + CH + S + 6);
    rst_n = 1'b0;
    #1;
    check("t6_r", r8, 0);
    check("t6_g", g8, 0);
    check("t6_b", b8, 0);
    check("t6_busy", busy8, 0);
    check("t6_done", done8, 0);
    check("t6_filt", filt8, 0);
    check("t6_sat3", sat3, 0);
    q8.delete();
    q3.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fill_period(cyc + 2, cyc + 2 * FLEN, 4);
    start_frame(s);
    wait_until(s + FLEN + 2);
    check_drained("t6");

    // Randomised single frames.
    for (int k = 0; k < 4; k++) begin
      fill_rand(cyc + 2, cyc + 2 * FLEN);
      start_frame(s);
      wait_until(s + FLEN + 1 + int'($urandom_range(0, 3)));
    end
    wait_until(cyc + 3);
    check_drained("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
